serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4; operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand pair X/Y present.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: X  input  WIDTH  minuend, unsigned.
REQ-007 Port: Y  input  WIDTH  subtrahend, unsigned.
REQ-008 Port: out_valid  output  1  D/Bo hold a completed result.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: D  output  WIDTH  difference, (X - Y) mod 2^WIDTH.
REQ-011 Port: Bo  output  1  final borrow; 1 iff X < Y (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be decoded from the registered state.
REQ-014 In IDLE with in_valid=1 (accept edge), the block SHALL:
  - capture X and Y into shift registers
  - clear the borrow flop and the bit counter
  - enter RUN.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first:
  - d_i = x_i ^ y_i ^ b
  - b_next = (~x_i & y_i) | (~(x_i ^ y_i) & b)
  - d_i is shifted into the result register from the MSB side
  - the operand registers shift right
  - the counter increments.
REQ-016 After exactly WIDTH RUN cycles, the state SHALL become DONE; out_valid rises WIDTH+1 rising edges after the accept edge.
REQ-017 On entering DONE, D SHALL equal the full difference and Bo SHALL equal the last b_next.
REQ-018 In DONE, D and Bo SHALL hold stable while out_ready=0 (unbounded backpressure).
REQ-019 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; a new operand pair is accepted no earlier than the following edge (one idle bubble minimum).
REQ-020 in_valid, X and Y SHALL be ignored in RUN and DONE; operands are sampled only on the accept edge.
REQ-021 out_ready SHALL be ignored outside DONE.
REQ-022 D SHALL show intermediate shift contents during RUN; these are don't-care while out_valid=0.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a RUN.
REQ-024 Boundary results:
  - X=Y gives D=0, Bo=0
  - X=0, Y=2^WIDTH-1 gives D=1, Bo=1.

Reset
REQ-025 While rst=1 (asynchronously), the block SHALL hold:
  - state IDLE
  - in_ready=1, out_valid=0
  - D=0, Bo=0
  - borrow flop, counter and operand registers all 0.
REQ-026 rst asserted in RUN or DONE SHALL abort the operation with no result delivered.
REQ-027 After rst deassertion, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 A shared package serial_subtractor_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 Exactly one sub-module, full_subtractor, SHALL exist:
  - ports a, b, bin, d, bout
  - purely combinational
  - instantiated once for the per-bit step.
REQ-030 All registers SHALL reside in serial_subtractor.

Verification
REQ-031 WIDTH=4: accept X=7, Y=3 -> out_valid 5 edges later; D=4, Bo=0.
REQ-032 WIDTH=4: X=3, Y=7 -> D=12, Bo=1; X=0, Y=1 -> D=15, Bo=1; X=15, Y=15 -> D=0, Bo=0.
REQ-033 Backpressure: result X=9, Y=2 with out_ready=0 for 6 cycles:
  - D=7, Bo=0 held stable throughout
  - IDLE one edge after out_ready=1.
REQ-034 Operands ignored while busy: change X/Y and pulse in_valid during RUN -> result still from the originally accepted pair; in_ready=0 throughout.
REQ-035 Reset mid-RUN: assert rst after 2 RUN cycles -> immediately out_valid=0, in_ready=1, D=0; next op X=5, Y=5 -> D=0, Bo=0.
REQ-036 Random test: 1000 random pairs at WIDTH=4 and WIDTH=16 with random in_valid/out_ready gaps -> every result matches (X-Y) mod 2^WIDTH and borrow = (X<Y).

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the step needs a borrow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshakes: one bit per cycle, LSB first,
// result held in DONE until the consumer takes it.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_fs (
        .a    (x_sr[0]),
        .b    (y_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (b_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x_sr   <= '0;
            y_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sr   <= X;
                        y_sr   <= Y;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
                    x_sr   <= x_sr >> 1;
                    y_sr   <= y_sr >> 1;
                    borrow <= b_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign D         = d_sr;
    assign Bo        = borrow;

endmodule
